// File: rtl/neuron_seq_ctrl.sv
// Single-neuron evaluation sequencer: streams weighted terms through a shared
// registered adder into a saturating accumulator, adds bias, applies optional ReLU.
//
// state  | meaning
// IDLE   | waiting for start; result and sat_flag from last evaluation held
// FETCH  | in_ready high, presenting acc + in_data to the adder
// WAIT   | capturing the adder result for the accepted term
// BIAS   | presenting acc + latched bias to the adder
// BWAIT  | capturing the biased sum, loading the output register
// OUT    | result valid, holding until out_ready
module neuron_seq_ctrl #(
  parameter int NUM_INPUTS = 4,
  parameter bit RELU_EN    = 1'b1,
  parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bias,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] add_in1,
  output logic [7:0]  add_in2,
  input  logic [15:0] add_sum,
  input  logic        add_carry,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        sat_flag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_BIAS  = 3'd3,
    S_BWAIT = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_INPUTS - 1);

  state_t             state_q;
  logic [15:0]        acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         bias_q;
  logic               sat_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        out_data_q;
  logic               busy_q;

  logic [15:0]        acc_d;
  logic               sat_hit;

  function automatic logic [15:0] relu_f(input logic [15:0] v);
    return (RELU_EN && v[15]) ? 16'h0000 : v;
  endfunction

  // The 17th sum bit disagreeing with bit 15 means the 16-bit result wrapped.
  always_comb begin
    sat_hit = (add_carry != add_sum[15]);
    acc_d   = add_sum;
    if (sat_hit) acc_d = add_carry ? 16'h8000 : 16'h7FFF;
  end

  always_comb begin
    add_in1 = 16'h0000;
    add_in2 = 8'h00;
    case (state_q)
      S_FETCH: begin
        add_in1 = acc_q;
        add_in2 = in_data;
      end
      S_BIAS: begin
        add_in1 = acc_q;
        add_in2 = bias_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      bias_q      <= 8'h00;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q      <= 16'h0000;
            cnt_q      <= '0;
            bias_q     <= bias;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (sat_hit) sat_q <= 1'b1;
          if (cnt_q == LAST_TERM) begin
            state_q <= S_BIAS;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_BIAS: begin
          state_q <= S_BWAIT;
        end
        S_BWAIT: begin
          acc_q       <= acc_d;
          if (sat_hit) sat_q <= 1'b1;
          out_valid_q <= 1'b1;
          out_data_q  <= relu_f(acc_d);
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign sat_flag  = sat_q;

endmodule
